mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single physical-memory port between the L1 D-cache and the L1 I-cache.
- Includes the grant state machine, the address/data steering muxes and response routing.
- Uses fixed D-over-I priority, with a bounded-starvation override so the I-cache is never locked out indefinitely.
- Sits between the two L1 caches and the physical-memory or L2 interface.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache-line data width
STARVE_LIMIT, 4, max consecutive D grants while an I request waits (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write (writeback) request
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write line
d_resp  out  1  D request complete, one-cycle pulse
d_rdata  out  LINE_W  read line to D-cache
i_read  in  1  I-cache line read request (I-cache never writes)
i_address  in  ADDR_W  I-cache line address
i_resp  out  1  I request complete, one-cycle pulse
i_rdata  out  LINE_W  read line to I-cache
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write line
pmem_resp  in  1  memory completion pulse
pmem_rdata  in  LINE_W  memory read line

Behaviour:
- States: IDLE, GRANT_D, GRANT_I. State and starvation counter (starve_cnt, width $clog2(STARVE_LIMIT+1)) are registered.
- rst asserted, at any time including mid-transfer: state=IDLE, starve_cnt=0. All strobes and resps are 0 while rst is high. Any in-flight memory transaction is abandoned; the memory side must also be reset.
- Outputs are combinational from state and inputs:
  - pmem_read = (GRANT_D & d_read & ~d_write) | (GRANT_I & i_read)
  - pmem_write = GRANT_D & d_write
  - pmem_address/pmem_wdata = D signals in GRANT_D, otherwise I address and zero wdata
  - d_resp = GRANT_D & pmem_resp; i_resp = GRANT_I & pmem_resp
  - d_rdata = i_rdata = pmem_rdata (broadcast; only the resp qualifies it)
- IDLE transitions, evaluated at the clock edge:
  - D pending (d_read|d_write) and not (i_read & starve_cnt==STARVE_LIMIT) -> GRANT_D.
  - Else i_read -> GRANT_I.
  - Else stay IDLE.
- Grant latency: a request seen in IDLE drives pmem strobes on the next cycle. Minimum request-to-resp is 1 + memory latency.
- GRANT_x transitions:
  - pmem_resp -> IDLE.
  - Owner drops its request before resp (abort) -> IDLE next cycle; strobes fall the same cycle the request falls.
  - Otherwise hold. The grant is never preempted.
- Mandatory IDLE cycle after every resp, so a requester that de-asserts on resp is never re-granted a stale request. Back-to-back throughput is therefore one transfer per (memory latency + 2) cycles.
- starve_cnt updates on transitions out of IDLE:
  - GRANT_D with i_read high: increment, saturating at STARVE_LIMIT.
  - GRANT_I: clear.
  - GRANT_D with i_read low: clear.
- Simultaneous d and i requests with starve_cnt<STARVE_LIMIT -> D wins. With starve_cnt==STARVE_LIMIT -> I wins, then the counter clears.
- d_read & d_write both high is illegal. Write wins and pmem_read stays 0. A simulation-only assertion flags the condition.
- pmem_resp in IDLE is ignored: no resp output, no state change.
- Requests must hold address/data stable from assertion until resp. The arbiter does not latch them.

Decomposition:
- Package mem_arbiter_types holds:
  - state enum {IDLE, GRANT_D, GRANT_I}
  - ADDR_W/LINE_W defaults as localparams
- One sub-module, mem_arbiter_fsm: state register, next-state logic and starvation counter. It outputs the grant_d and grant_i one-hots.
- The top level, mem_arbiter, holds only the steering muxes and resp gating.

Test Plan:
- Reset mid-GRANT_D (d_read held, rst pulsed at cycle 3, memory latency 5) -> next cycle pmem_read=0, d_resp never fires, state IDLE; after rst release, d_read is re-granted with pmem_read=1 one cycle later.
- Lone I read at 0x0000_1040, memory latency 3 -> pmem_read high cycles 1-4, pmem_address=0x1040, i_resp pulses once at cycle 4, i_rdata=pmem_rdata, d_resp=0 throughout.
- Simultaneous d_write 0x2000 and i_read 0x3000 -> D granted first (pmem_write=1, pmem_wdata=d_wdata); after resp and one IDLE cycle, I is granted (pmem_read=1, address 0x3000).
- Continuous d_read with i_read held, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,...; starve_cnt reads 4 just before the I grant and 0 after it.
- Abort: d_read drops at cycle 2 of GRANT_D before pmem_resp -> pmem_read falls the same cycle, state IDLE next cycle, late pmem_resp produces no d_resp.
- d_read=d_write=1 -> pmem_write=1, pmem_read=0, assertion fires.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the L1 D/I-cache memory-port arbiter.
// Holds the grant-state encoding and the default bus widths.
package mem_arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

endpackage

// File: rtl/mem_arbiter_chk.sv
// Simulation checker: a D-cache read and write asserted together is illegal
// (the arbiter resolves it as a write).
module mem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_read,
  input logic d_write
);

  d_rw_exclusive_a: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $warning("mem_arbiter: d_read and d_write asserted together, write takes the port");

endmodule

// File: rtl/mem_arbiter_fsm.sv
// Grant state machine for the shared memory port: fixed D-over-I priority
// with a saturating starvation counter that forces an I grant.
module mem_arbiter_fsm
  import mem_arbiter_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_read,
  input  logic d_write,
  input  logic i_read,
  input  logic pmem_resp,
  output logic grant_d,
  output logic grant_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_s;
  logic             d_pend_s;
  logic             i_turn_s;

  assign d_pend_s = d_read | d_write;
  // I has waited through STARVE_LIMIT D grants and now takes precedence.
  assign i_turn_s = i_read & (starve_cnt_r == LIMIT_C);

  // State and starvation-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    case (state_r)
      IDLE: begin
        if (d_pend_s && !i_turn_s) begin
          state_s = GRANT_D;
          if (i_read) begin
            if (starve_cnt_r != LIMIT_C) begin
              starve_cnt_s = starve_cnt_r + CNT_W'(1);
            end else begin
              starve_cnt_s = starve_cnt_r;
            end
          end else begin
            starve_cnt_s = {CNT_W{1'b0}};
          end
        end else if (i_read) begin
          state_s      = GRANT_I;
          starve_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      // A grant ends on completion or when the owner withdraws; never preempted.
      GRANT_D: begin
        if (pmem_resp || !d_pend_s) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_D;
        end
      end
      GRANT_I: begin
        if (pmem_resp || !i_read) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_I;
        end
      end
      default: begin
        state_s      = IDLE;
        starve_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // One-hot grant decode.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_r)
      GRANT_D: grant_d = 1'b1;
      GRANT_I: grant_i = 1'b1;
      default: begin
        grant_d = 1'b0;
        grant_i = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the L1 D-cache and I-cache:
// grant FSM plus address/data steering and response routing.
module mem_arbiter
  import mem_arbiter_types::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int LINE_W       = LINE_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  logic grant_d_s;
  logic grant_i_s;

  mem_arbiter_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .d_read   (d_read),
    .d_write  (d_write),
    .i_read   (i_read),
    .pmem_resp(pmem_resp),
    .grant_d  (grant_d_s),
    .grant_i  (grant_i_s)
  );

  mem_arbiter_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .d_read (d_read),
    .d_write(d_write)
  );

  // Strobes follow the owner's request directly so an abort drops them at once.
  always_comb begin
    pmem_read  = (grant_d_s & d_read & ~d_write) | (grant_i_s & i_read);
    pmem_write = grant_d_s & d_write;
    if (grant_d_s) begin
      pmem_address = d_address;
      pmem_wdata   = d_wdata;
    end else begin
      pmem_address = i_address;
      pmem_wdata   = {LINE_W{1'b0}};
    end
  end

  // Read data is broadcast; only the per-requester resp qualifies it.
  always_comb begin
    d_resp  = grant_d_s & pmem_resp;
    i_resp  = grant_i_s & pmem_resp;
    d_rdata = pmem_rdata;
    i_rdata = pmem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory responder.
module tb_mem_arbiter;
  import mem_arbiter_types::*;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          d_read, d_write, i_read;
  logic [AW-1:0] d_address, i_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp, i_resp;
  logic [LW-1:0] d_rdata, i_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  int err_cnt = 0;
  int chk_cnt = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  logic auto_resp = 1'b1;
  logic man_resp  = 1'b0;

  localparam logic [LW-1:0] RD_A = {8{32'hC0DE_1040}};
  localparam logic [LW-1:0] WD_B = {8{32'hB0B0_2000}};
  localparam logic [LW-1:0] WD_F = {8{32'hF00D_5000}};

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: resp on the (mem_lat+1)-th cycle of an active strobe.
  initial begin
    pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !(pmem_read || pmem_write)) begin
        mem_cnt   = 0;
        pmem_resp = man_resp;
      end else begin
        mem_cnt   = mem_cnt + 1;
        pmem_resp = man_resp | (auto_resp & (mem_cnt == mem_lat + 1));
      end
    end
  end

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    rst = 1'b1; d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    d_address = '0; i_address = '0; d_wdata = '0; pmem_rdata = '0;
    step(); settle();
    check_eq("rst_state", dut.u_fsm.state_r, IDLE);
    check_eq("rst_cnt", dut.u_fsm.starve_cnt_r, 0);
    check_eq("rst_rd", pmem_read, 1'b0);
    check_eq("rst_wr", pmem_write, 1'b0);
    check_eq("rst_dresp", d_resp, 1'b0);
    check_eq("rst_iresp", i_resp, 1'b0);
    step(); rst = 1'b0; settle();
    check_eq("rel_state", dut.u_fsm.state_r, IDLE);

    // Lone I read, latency 3.
    step(); mem_lat = 3; i_address = 32'h0000_1040; i_read = 1'b1; pmem_rdata = RD_A; settle();
    check_eq("a_idle_rd", pmem_read, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(); settle();
      check_eq("a_rd", pmem_read, 1'b1);
      check_eq("a_addr", pmem_address, 32'h0000_1040);
      check_eq("a_iresp", i_resp, (c == 4));
      check_eq("a_dresp", d_resp, 1'b0);
    end
    check_eq("a_irdata", i_rdata, RD_A);
    check_eq("a_drdata", d_rdata, RD_A);
    step(); i_read = 1'b0; settle();
    check_eq("a_post_state", dut.u_fsm.state_r, IDLE);
    check_eq("a_post_rd", pmem_read, 1'b0);

    // Simultaneous D write and I read, latency 1.
    step(); mem_lat = 1;
    d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = WD_B;
    i_read = 1'b1; i_address = 32'h0000_3000; settle();
    step(); settle();
    check_eq("b_wr", pmem_write, 1'b1);
    check_eq("b_rd", pmem_read, 1'b0);
    check_eq("b_waddr", pmem_address, 32'h0000_2000);
    check_eq("b_wdata", pmem_wdata, WD_B);
    step(); settle();
    check_eq("b_dresp", d_resp, 1'b1);
    step(); d_write = 1'b0; settle();
    check_eq("b_gap_state", dut.u_fsm.state_r, IDLE);
    check_eq("b_gap_rd", pmem_read, 1'b0);
    check_eq("b_gap_cnt", dut.u_fsm.starve_cnt_r, 1);
    step(); settle();
    check_eq("b_ird", pmem_read, 1'b1);
    check_eq("b_iaddr", pmem_address, 32'h0000_3000);
    check_eq("b_iwdata", pmem_wdata, {LW{1'b0}});
    step(); settle();
    check_eq("b_iresp", i_resp, 1'b1);
    step(); i_read = 1'b0; settle();
    check_eq("b_end_cnt", dut.u_fsm.starve_cnt_r, 0);

    // Starvation: D and I held, latency 0 -> D,D,D,D,I,D.
    step(); mem_lat = 0;
    d_read = 1'b1; d_address = 32'h0000_6000; i_read = 1'b1; i_address = 32'h0000_7000; settle();
    check_eq("c_cnt0", dut.u_fsm.starve_cnt_r, 0);
    for (int g = 0; g < 6; g++) begin
      step(); settle();
      check_eq("c_dresp", d_resp, (g != 4));
      check_eq("c_iresp", i_resp, (g == 4));
      check_eq("c_addr", pmem_address, (g == 4) ? 32'h0000_7000 : 32'h0000_6000);
      step();
      if (g == 5) begin
        d_read = 1'b0; i_read = 1'b0;
      end
      settle();
      check_eq("c_state", dut.u_fsm.state_r, IDLE);
      check_eq("c_cnt", dut.u_fsm.starve_cnt_r, (g < 4) ? (g + 1) : ((g == 4) ? 0 : 1));
    end

    // Abort, then a late resp in IDLE.
    auto_resp = 1'b0;
    step(); d_read = 1'b1; d_address = 32'h0000_4000; settle();
    step(); settle();
    check_eq("d_rd_on", pmem_read, 1'b1);
    step(); d_read = 1'b0; settle();
    check_eq("d_rd_drop", pmem_read, 1'b0);
    check_eq("d_still_gd", dut.u_fsm.state_r, GRANT_D);
    step(); man_resp = 1'b1; settle();
    check_eq("d_idle", dut.u_fsm.state_r, IDLE);
    check_eq("d_late_dresp", d_resp, 1'b0);
    check_eq("d_late_iresp", i_resp, 1'b0);
    step(); man_resp = 1'b0; settle();
    check_eq("d_idle_hold", dut.u_fsm.state_r, IDLE);
    auto_resp = 1'b1;

    // Reset mid-GRANT_D, latency 5.
    step(); mem_lat = 5; d_read = 1'b1; d_address = 32'h0000_8000; settle();
    step(); settle();
    check_eq("e_rd_on", pmem_read, 1'b1);
    step(); settle();
    step(); rst = 1'b1; settle();
    check_eq("e_rst_rd", pmem_read, 1'b0);
    check_eq("e_rst_state", dut.u_fsm.state_r, IDLE);
    check_eq("e_rst_dresp", d_resp, 1'b0);
    step(); rst = 1'b0; settle();
    check_eq("e_rel_rd", pmem_read, 1'b0);
    for (int c = 5; c <= 10; c++) begin
      step(); settle();
      check_eq("e_regrant_rd", pmem_read, 1'b1);
      check_eq("e_dresp", d_resp, (c == 10));
    end
    step(); d_read = 1'b0; settle();
    check_eq("e_end_state", dut.u_fsm.state_r, IDLE);

    // Illegal read+write: write wins.
    step(); mem_lat = 0; d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_5000; d_wdata = WD_F; settle();
    step(); settle();
    check_eq("f_wr", pmem_write, 1'b1);
    check_eq("f_rd", pmem_read, 1'b0);
    check_eq("f_wdata", pmem_wdata, WD_F);
    check_eq("f_dresp", d_resp, 1'b1);
    step(); d_read = 1'b0; d_write = 1'b0; settle();
    check_eq("f_end_state", dut.u_fsm.state_r, IDLE);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
